// File: rtl/cpu_control_unit.sv
// Multi-cycle fetch/decode/execute sequencer for the 8-bit datapath.
// Runs PROG_LEN instructions starting at pc=0, then parks in DONE until restarted.
//
//   state  | meaning
//   IDLE   | after reset, waiting for start
//   FETCH  | ir_en high, pc presented to inst_reg
//   DECODE | latch instruction word, dispatch on opcode
//   RDA    | read Rs1 (captured into alu_a at the end of this cycle)
//   RDB    | read Rs2 (captured into alu_b, alu_op set at the end of this cycle)
//   EXEC   | operands stable at the alu
//   WB     | write Rd with immediate (LOAD) or alu result (ADD/SUB)
//   NEXT   | retire instruction, advance pc or finish
//   DONE   | run complete, waiting for start
module cpu_control_unit #(
  parameter int PROG_LEN = 5,
  parameter int PC_W     = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  output logic [PC_W-1:0] pc,
  output logic            ir_en,
  input  logic [15:0]     ir_data,
  output logic [1:0]      reg_addr,
  output logic            reg_rd,
  output logic            reg_wr,
  output logic [7:0]      reg_wdata,
  input  logic [7:0]      reg_rdata,
  output logic [2:0]      alu_op,
  output logic [7:0]      alu_a,
  output logic [7:0]      alu_b,
  input  logic [7:0]      alu_out,
  output logic            busy,
  output logic            done,
  output logic [7:0]      instr_cnt
);

  typedef enum logic [3:0] {
    S_IDLE, S_FETCH, S_DECODE, S_RDA, S_RDB, S_EXEC, S_WB, S_NEXT, S_DONE
  } state_t;

  localparam logic [PC_W-1:0] PC_LAST = PC_W'(PROG_LEN - 1);

  state_t      state, state_nxt;
  logic [15:0] ir;
  logic        is_load;
  logic        is_sub;

  assign is_load = (ir[15:12] == 4'b1000);
  assign is_sub  = (ir[15:12] == 4'b0001);

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Datapath registers: pc, instruction latch, alu operands, retire counter
  always_ff @(posedge clk) begin
    if (rst) begin
      pc        <= '0;
      ir        <= '0;
      alu_a     <= '0;
      alu_b     <= '0;
      alu_op    <= '0;
      instr_cnt <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            pc        <= '0;
            instr_cnt <= '0;
          end
        end
        S_DECODE: ir <= ir_data;
        S_RDA:    alu_a <= reg_rdata;
        S_RDB: begin
          alu_b  <= reg_rdata;
          alu_op <= is_sub ? 3'b001 : 3'b000;
        end
        S_NEXT: begin
          instr_cnt <= instr_cnt + 8'd1;
          if (pc != PC_LAST) pc <= pc + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Next-state decode and Moore control outputs.
  // The write data in WB passes the alu result straight through: the alu is
  // combinational on the registered operands, and its result is consumed in
  // the same cycle the register file write is strobed.
  always_comb begin
    state_nxt = state;
    ir_en     = 1'b0;
    reg_addr  = 2'b00;
    reg_rd    = 1'b0;
    reg_wr    = 1'b0;
    reg_wdata = 8'h00;
    busy      = (state != S_IDLE) && (state != S_DONE);
    done      = (state == S_DONE);
    case (state)
      S_IDLE:   if (start) state_nxt = S_FETCH;
      S_FETCH: begin
        ir_en     = 1'b1;
        state_nxt = S_DECODE;
      end
      S_DECODE: begin
        case (ir_data[15:12])
          4'b1000:          state_nxt = S_WB;
          4'b0000, 4'b0001: state_nxt = S_RDA;
          default:          state_nxt = S_NEXT;
        endcase
      end
      S_RDA: begin
        reg_addr  = ir[5:4];
        reg_rd    = 1'b1;
        state_nxt = S_RDB;
      end
      S_RDB: begin
        reg_addr  = ir[1:0];
        reg_rd    = 1'b1;
        state_nxt = S_EXEC;
      end
      S_EXEC:   state_nxt = S_WB;
      S_WB: begin
        reg_addr  = ir[9:8];
        reg_wr    = 1'b1;
        reg_wdata = is_load ? ir[7:0] : alu_out;
        state_nxt = S_NEXT;
      end
      S_NEXT:   state_nxt = (pc == PC_LAST) ? S_DONE : S_FETCH;
      S_DONE:   if (start) state_nxt = S_FETCH;
      default:  state_nxt = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_cpu_control_unit.sv
// Bench for cpu_control_unit: models inst_reg, register file and alu around the
// sequencer, scoreboards every register write, and checks run timing and results.
module tb_cpu_control_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  pc;
  logic        ir_en;
  logic [15:0] ir_data;
  logic [1:0]  reg_addr;
  logic        reg_rd;
  logic        reg_wr;
  logic [7:0]  reg_wdata;
  logic [7:0]  reg_rdata;
  logic [2:0]  alu_op;
  logic [7:0]  alu_a;
  logic [7:0]  alu_b;
  logic [7:0]  alu_out;
  logic        busy;
  logic        done;
  logic [7:0]  instr_cnt;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [1:0] addr;
    logic [7:0] data;
    logic [2:0] op;
    bit         chk_op;
  } wr_t;

  wr_t sbq[$];
  wr_t e;

  logic [15:0] imem [0:3];
  logic [7:0]  regs [0:3];

  cpu_control_unit #(.PROG_LEN(3), .PC_W(8)) dut (
    .clk(clk), .rst(rst), .start(start), .pc(pc), .ir_en(ir_en),
    .ir_data(ir_data), .reg_addr(reg_addr), .reg_rd(reg_rd), .reg_wr(reg_wr),
    .reg_wdata(reg_wdata), .reg_rdata(reg_rdata), .alu_op(alu_op),
    .alu_a(alu_a), .alu_b(alu_b), .alu_out(alu_out), .busy(busy),
    .done(done), .instr_cnt(instr_cnt)
  );

  always #5 clk = ~clk;

  // inst_reg: registered read when enabled
  always @(posedge clk) if (ir_en) ir_data <= imem[pc[1:0]];

  // Register file: combinational read; a write coinciding with system reset is dropped
  assign reg_rdata = regs[reg_addr];
  always @(posedge clk) if (reg_wr && !rst) regs[reg_addr] <= reg_wdata;

  assign alu_out = (alu_op == 3'b001) ? (alu_a - alu_b) : (alu_a + alu_b);

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [1:0] a, input logic [7:0] d, input logic [2:0] op, input bit c);
    wr_t w;
    w.addr = a; w.data = d; w.op = op; w.chk_op = c;
    sbq.push_back(w);
  endtask

  // Per-cycle invariants and scoreboard compare of register writes
  always @(negedge clk) begin
    if (!rst) begin
      chk("rd_wr_excl", 64'(reg_rd && reg_wr), 64'd0);
      chk("pc_range", 64'(pc < 8'd3), 64'd1);
      if (ir_en) chk("ir_en_fetch", {61'd0, reg_rd, reg_wr, busy}, 64'd1);
      if (reg_wr) begin
        if (sbq.size() == 0) chk("sb_unexpected_wr", {62'd0, reg_addr}, 64'h100);
        else begin
          e = sbq.pop_front();
          chk("sb_addr", 64'(reg_addr), 64'(e.addr));
          chk("sb_data", 64'(reg_wdata), 64'(e.data));
          if (e.chk_op) chk("sb_alu_op", 64'(alu_op), 64'(e.op));
        end
      end
    end
  end

  // Pulse start, confirm FETCH from pc=0, count cycles to done.
  // glitch: extra start pulses while busy, which must be ignored.
  task automatic run(input string tag, input int exp_cycles, input bit glitch);
    int n;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk({tag, "_fetch"}, {ir_en, busy, pc, instr_cnt}, {46'd0, 1'b1, 1'b1, 16'd0});
    n = 0;
    while (!done && n < 200) begin
      start = glitch && (n == 3 || n == 8);
      @(posedge clk); #1;
      n++;
    end
    start = 1'b0;
    chk({tag, "_cycles"}, 64'(n), 64'(exp_cycles));
    chk({tag, "_busy_done"}, {62'd0, busy, done}, 64'd1);
    chk({tag, "_instr_cnt"}, 64'(instr_cnt), 64'd3);
    chk({tag, "_sb_empty"}, 64'(sbq.size()), 64'd0);
  endtask

  initial begin
    int n;
    rst = 1'b1;
    start = 1'b1;
    imem[0] = 16'h8005; imem[1] = 16'h8103; imem[2] = 16'h0201; imem[3] = 16'hF000;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_outputs", {14'd0, pc, ir_en, reg_addr, reg_rd, reg_wr, reg_wdata, alu_op,
        alu_a, alu_b, busy, done, instr_cnt}, 64'd0);
    start = 1'b0;
    rst = 1'b0;
    @(posedge clk); #1;
    chk("idle_no_busy", {62'd0, busy, done}, 64'd0);

    // LOAD R0,5; LOAD R1,3; ADD R2,R0,R1
    push(2'd0, 8'd5, 3'd0, 1'b0);
    push(2'd1, 8'd3, 3'd0, 1'b0);
    push(2'd2, 8'd8, 3'b000, 1'b1);
    run("t1", 15, 1'b0);
    chk("t1_r2", 64'(regs[2]), 64'd8);
    chk("t1_pc_held", 64'(pc), 64'd2);

    // LOAD R0,3; LOAD R1,5; SUB R3,R0,R1
    imem[0] = 16'h8003; imem[1] = 16'h8105; imem[2] = 16'h1301;
    push(2'd0, 8'd3, 3'd0, 1'b0);
    push(2'd1, 8'd5, 3'd0, 1'b0);
    push(2'd3, 8'hFE, 3'b001, 1'b1);
    run("t2", 15, 1'b0);
    chk("t2_r3", 64'(regs[3]), 64'hFE);

    // LOAD R0,7; NOP (opcode 1111); ADD R1,R0,R0
    imem[0] = 16'h8007; imem[1] = 16'hF000; imem[2] = 16'h0100;
    push(2'd0, 8'd7, 3'd0, 1'b0);
    push(2'd1, 8'd14, 3'b000, 1'b1);
    run("t3", 14, 1'b0);
    chk("t3_r1", 64'(regs[1]), 64'd14);

    // Reset during WB of ADD R2: write abandoned, R2 keeps 8
    imem[0] = 16'h8009; imem[1] = 16'h8101; imem[2] = 16'h0201;
    push(2'd0, 8'd9, 3'd0, 1'b0);
    push(2'd1, 8'd1, 3'd0, 1'b0);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n = 0;
    while (!(reg_wr && reg_addr == 2'd2) && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    chk("t4_reach_wb", 64'(n < 200), 64'd1);
    rst = 1'b1;
    start = 1'b1;
    @(posedge clk); #1;
    chk("t4_reset_outputs", {14'd0, pc, ir_en, reg_addr, reg_rd, reg_wr, reg_wdata, alu_op,
        alu_a, alu_b, busy, done, instr_cnt}, 64'd0);
    chk("t4_r2_kept", 64'(regs[2]), 64'd8);
    chk("t4_sb_empty", 64'(sbq.size()), 64'd0);
    start = 1'b0;
    rst = 1'b0;
    @(posedge clk); #1;
    push(2'd0, 8'd9, 3'd0, 1'b0);
    push(2'd1, 8'd1, 3'd0, 1'b0);
    push(2'd2, 8'd10, 3'b000, 1'b1);
    run("t4_rerun", 15, 1'b0);
    chk("t4_r2_new", 64'(regs[2]), 64'd10);

    // start pulses while busy are ignored; restart from DONE repeats the run
    imem[0] = 16'h8005; imem[1] = 16'h8103; imem[2] = 16'h0201;
    push(2'd0, 8'd5, 3'd0, 1'b0);
    push(2'd1, 8'd3, 3'd0, 1'b0);
    push(2'd2, 8'd8, 3'b000, 1'b1);
    run("t5_glitch", 15, 1'b1);
    chk("t5_r2", 64'(regs[2]), 64'd8);
    repeat (3) @(posedge clk);
    #1;
    chk("t5_done_hold", {56'd0, instr_cnt}, 64'd3);
    push(2'd0, 8'd5, 3'd0, 1'b0);
    push(2'd1, 8'd3, 3'd0, 1'b0);
    push(2'd2, 8'd8, 3'b000, 1'b1);
    run("t5_rerun", 15, 1'b0);
    chk("t5_r2_again", 64'(regs[2]), 64'd8);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

endmodule
